sm4_key_expand: RTL and testbench
=================================

# sm4_key_expand

Parametrised SM4 key-schedule engine. Accepts a 128-bit master key over a valid/ready handshake and expands it into the 32 round keys. Round constants CK are generated arithmetically, not from a table, and the keys are held in an internal buffer. Sits between the key register interface and the SM4 round datapath, which reads keys by index in forward (encrypt) or reversed (decrypt) order.

## Interface
- `RPC`, default 1: rounds computed per clock; legal values are 1, 2, 4. Any other value is an elaboration error.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: master key offered.
- `key_ready` out 1: block can accept a key. High in IDLE and READY.
- `key` in 128: master key MK, MK0 in bits [127:96].
- `busy` out 1: high while in EXPAND.
- `keys_ready` out 1: buffer holds a complete, valid schedule.
- `rd_en` in 1: round-key read request.
- `rd_dec` in 1: 1 means decrypt order, so the physical index is 31-rd_idx.
- `rd_idx` in 5: logical round index.
- `rd_key` out 32: round key read data.
- `rd_valid` out 1: rd_key valid this cycle.

## Operation
- **States:**
  - IDLE → EXPAND on a key handshake (key_valid & key_ready).
  - EXPAND → READY when the round counter reaches 32.
  - READY → EXPAND on a new key handshake.
  - No other transitions.
- **Handshake edge:**
  - K0..K3 ← MK0..MK3 XOR FK, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Round counter ← 0.
  - keys_ready ← 0.
- **Each EXPAND cycle computes RPC chained rounds:**
  - rk_i = K_i ^ T'(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i).
  - T' = tau (4× sm4_sbox), then L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - rk_i is written to buf[i], and the 4-word window shifts by one.
- **CK_i generation:**
  - Byte j (j=0 is the MSB) of CK_i = (28·i + 7·j) mod 256, computed with 8-bit wrap-around arithmetic.
  - Check value: CK_0 = 00070E15.
- **Counter:**
  - 6 bits; increments by RPC per EXPAND cycle.
  - Terminal value is 32; no modulo wrap inside a schedule.
- **Reads:**
  - Accepted only when keys_ready = 1.
  - rd_en while keys_ready = 0 produces rd_valid = 0 on the next cycle, and rd_key keeps its previous value.
- **Simultaneous events:**
  - rd_en on the same edge as a new key handshake in READY is served from the old schedule, because buffer writes begin on the following edge.
  - key_valid during EXPAND is ignored (key_ready = 0). The key must be held until accepted.
- **Reset mid-expansion:**
  - Returns to IDLE and clears keys_ready.
  - Buffer contents are don't-care and are never readable until a full schedule completes.

## Timing
- **Reset values:**
  - key_ready = 1, busy = 0, keys_ready = 0, rd_valid = 0, rd_key = 0.
  - State = IDLE, counter = 0.
- **Expansion latency:** handshake at edge E0; busy is high from E0 up to E0+N, where N = 32/RPC (32, 16 or 8 cycles).
  - keys_ready rises and key_ready returns high at E0+N.
- **Read latency:** 1 cycle. rd_en sampled at edge E gives rd_key/rd_valid registered at E, visible until the next edge.
- **rd_valid:** a single-cycle pulse per accepted read; back-to-back reads are allowed every cycle.

## Structure
- **Package sm4_pkg:**
  - FK constants.
  - The L' rotation amounts 13 and 23.
  - Round count 32.
  - A function computing CK_i from a 5-bit i. This function replaces the legacy constant table and is shared with future full-unrolled cores.
- **Sub-module sm4_key_round:** combinational T' plus XOR for one round.
  - Instantiated RPC times in a chain.
  - Contains 4× the existing sm4_sbox.
- **Top level:** FSM, counter, 4-word window, 32×32 buffer and read port.

## Test plan
- **Standard vector:** MK = 0123456789ABCDEFFEDCBA9876543210, RPC=1 → keys_ready exactly 32 cycles after the handshake. Reads must return:
  - idx0 = F12186F9
  - idx1 = 41662B61
  - idx31 = 9124A012
- **Decrypt order:** same key, rd_dec=1, rd_idx=0 → F12186F9 must not appear; the read returns 9124A012, and rd_idx=31 returns F12186F9.
- **Parameter sweep:** RPC=2 and RPC=4 → identical 32-key buffer contents, with keys_ready after 16 and 8 cycles respectively.
- **Rekey and read collision:** new key handshake in READY with rd_en on the same edge → read returns the old-key value. keys_ready drops on the following cycle, and key_ready drops throughout EXPAND.
- **Reset mid-expansion:** rst_n low at expansion cycle 10 → all outputs at reset values immediately. A subsequent rd_en gives rd_valid=0, and a reload then yields correct keys.
- **Read guard:** rd_en before any key is loaded → rd_valid stays 0 and rd_key stays 0.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants and helpers: FK, L' rotations, and the
// arithmetic CK generator that stands in for the old constant table.
package sm4_pkg;

  localparam int NUM_ROUNDS = 32;
  localparam int ROT_A      = 13;
  localparam int ROT_B      = 23;

  // Index 0 is the leftmost word, so FK[0] pairs with MK0.
  localparam logic [0:3][31:0] FK = {32'hA3B1BAC6, 32'h56AA3350,
                                     32'h677D9197, 32'hB27022DC};

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} state_e;

  // Byte j (MSB first) is 28*i + 7*j, wrapping at 8 bits.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] ck;
    logic [7:0]  b;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      b = 8'(i) * 8'd28 + 8'(j) * 8'd7;
      ck[31-8*j -: 8] = b;
    end
    return ck;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_key_expand_if.sv
// Key load handshake plus round-key read port of the SM4 key schedule.
interface sm4_key_expand_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         busy;
  logic         keys_ready;
  logic         rd_en;
  logic         rd_dec;
  logic [4:0]   rd_idx;
  logic [31:0]  rd_key;
  logic         rd_valid;

  modport slave (
    input  key_valid, key, rd_en, rd_dec, rd_idx,
    output key_ready, busy, keys_ready, rd_key, rd_valid
  );

  modport master (
    output key_valid, key, rd_en, rd_dec, rd_idx,
    input  key_ready, busy, keys_ready, rd_key, rd_valid
  );
endinterface

// File: rtl/sm4_key_round.sv
// One key-schedule round: rk = K0 ^ L'(tau(K1 ^ K2 ^ K3 ^ CK)).
module sm4_key_round import sm4_pkg::*; (
  input  logic [3:0][31:0] win,
  input  logic [31:0]      ck,
  output logic [31:0]      rk
);
  logic [31:0] a, b;

  assign a = win[1] ^ win[2] ^ win[3] ^ ck;

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    sm4_sbox u_sbox (.din(a[8*j +: 8]), .dout(b[8*j +: 8]));
  end

  assign rk = win[0] ^ b ^ rotl32(b, ROT_A) ^ rotl32(b, ROT_B);
endmodule

// File: rtl/sm4_sbox.sv
// SM4 byte substitution, purely combinational lookup.
module sm4_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [0:255][7:0] SBOX = {
    128'hD690E9FECCE13DB716B614C228FB2C05,
    128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62,
    128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8,
    128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887,
    128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1,
    128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F,
    128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8,
    128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684,
    128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };

  assign dout = SBOX[din];
endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into 32 buffered round keys,
// RPC rounds per clock, readable in encrypt or decrypt order.
module sm4_key_expand import sm4_pkg::*; #(
  parameter int RPC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sm4_key_expand_if.slave  kif
);
  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $error("sm4_key_expand: RPC must be 1, 2 or 4");
  end

  state_e                 state;
  logic [5:0]             cnt;
  logic [3:0][31:0]       win;
  logic [31:0]            kbuf [NUM_ROUNDS];
  logic [RPC:0][3:0][31:0] wchain;
  logic [RPC-1:0][31:0]   rk;
  logic                   key_ready_q, busy_q, keys_ready_q, rd_valid_q;
  logic [31:0]            rd_key_q;
  logic [4:0]             rd_phys;
  logic                   hs;

  // Window word 0 is K_i; each round retires it and appends rk_i as K_{i+4}.
  assign wchain[0] = win;
  for (genvar r = 0; r < RPC; r++) begin : g_round
    sm4_key_round u_round (
      .win (wchain[r]),
      .ck  (ck_word(cnt[4:0] + 5'(r))),
      .rk  (rk[r])
    );
    assign wchain[r+1] = {rk[r], wchain[r][3:1]};
  end

  assign hs      = kif.key_valid & key_ready_q;
  assign rd_phys = kif.rd_dec ? 5'd31 - kif.rd_idx : kif.rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      win          <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (hs) begin
            state        <= ST_EXPAND;
            cnt          <= '0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            keys_ready_q <= 1'b0;
            for (int j = 0; j < 4; j++) win[j] <= kif.key[127-32*j -: 32] ^ FK[j];
          end
        end
        ST_EXPAND: begin
          win <= wchain[RPC];
          cnt <= cnt + 6'(RPC);
          if (cnt + 6'(RPC) == 6'(NUM_ROUNDS)) begin
            state        <= ST_READY;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Buffer is only readable once keys_ready is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_EXPAND)
      for (int r = 0; r < RPC; r++) kbuf[cnt[4:0] + 5'(r)] <= rk[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (kif.rd_en && keys_ready_q) begin
        rd_valid_q <= 1'b1;
        rd_key_q   <= kbuf[rd_phys];
      end
    end
  end

  assign kif.key_ready  = key_ready_q;
  assign kif.busy       = busy_q;
  assign kif.keys_ready = keys_ready_q;
  assign kif.rd_valid   = rd_valid_q;
  assign kif.rd_key     = rd_key_q;
endmodule

// File: tb/tb_sm4_key_expand.sv
// Bench for sm4_key_expand: RPC=1/2/4 instances driven in lockstep, reads
// checked through a queue of expected results from a reference key schedule.
module tb_sm4_key_expand;
  localparam logic [127:0] MK1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] MK2 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam int RPCS[3] = '{1, 2, 4};
  localparam int NLAT[3] = '{32, 16, 8};
  localparam logic [31:0] TFK[4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  localparam logic [0:255][7:0] SB = {
    128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948};

  typedef struct {logic v; logic [31:0] k;} rd_exp_t;
  typedef struct packed {logic key_ready, busy, keys_ready, rd_valid; logic [31:0] rd_key;} outs_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         key_valid = 1'b0, rd_en = 1'b0, rd_dec = 1'b0;
  logic [127:0] key = '0;
  logic [4:0]   rd_idx = '0;
  int           n_chk = 0, n_err = 0;
  rd_exp_t      sbq[$];
  logic [31:0]  last_k = '0;
  logic [31:0]  mdl[32];
  logic [31:0]  old5;

  always #5 clk = ~clk;

  sm4_key_expand_if if1(), if2(), if4();
  assign if1.key_valid = key_valid; assign if1.key = key; assign if1.rd_en = rd_en;
  assign if1.rd_dec = rd_dec; assign if1.rd_idx = rd_idx;
  assign if2.key_valid = key_valid; assign if2.key = key; assign if2.rd_en = rd_en;
  assign if2.rd_dec = rd_dec; assign if2.rd_idx = rd_idx;
  assign if4.key_valid = key_valid; assign if4.key = key; assign if4.rd_en = rd_en;
  assign if4.rd_dec = rd_dec; assign if4.rd_idx = rd_idx;

  sm4_key_expand #(.RPC(1)) u_r1 (.clk(clk), .rst_n(rst_n), .kif(if1.slave));
  sm4_key_expand #(.RPC(2)) u_r2 (.clk(clk), .rst_n(rst_n), .kif(if2.slave));
  sm4_key_expand #(.RPC(4)) u_r4 (.clk(clk), .rst_n(rst_n), .kif(if4.slave));

  function automatic outs_t get_outs(input int d);
    case (d)
      0:       return {if1.key_ready, if1.busy, if1.keys_ready, if1.rd_valid, if1.rd_key};
      1:       return {if2.key_ready, if2.busy, if2.keys_ready, if2.rd_valid, if2.rd_key};
      default: return {if4.key_ready, if4.busy, if4.keys_ready, if4.rd_valid, if4.rd_key};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference schedule written straight from the algorithm; CK byte = 7*(4i+j).
  task automatic model(input logic [127:0] mk);
    logic [31:0] k[36];
    logic [31:0] a, b, ck;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ TFK[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
      a = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
      b = {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
      k[i+4] = k[i] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
      mdl[i] = k[i+4];
    end
  endtask

  // Advance one clock; sample 1ns later and retire at most one expected read.
  task automatic step();
    rd_exp_t e;
    outs_t   o;
    logic    ev;
    @(posedge clk); #1;
    ev = 1'b0;
    if (sbq.size() > 0) begin
      e  = sbq.pop_front();
      ev = e.v;
      if (e.v) last_k = e.k;
    end
    for (int d = 0; d < 3; d++) begin
      o = get_outs(d);
      chk($sformatf("rd_valid/rpc%0d", RPCS[d]), 32'(o.rd_valid), 32'(ev));
      chk($sformatf("rd_key/rpc%0d", RPCS[d]), o.rd_key, last_k);
    end
  endtask

  task automatic rd(input logic dec, input int idx, input logic v, input logic [31:0] k);
    rd_en = 1'b1; rd_dec = dec; rd_idx = 5'(idx);
    sbq.push_back('{v: v, k: k});
    step();
    rd_en = 1'b0;
  endtask

  task automatic status(input int k);
    outs_t o;
    logic  done;
    for (int d = 0; d < 3; d++) begin
      o    = get_outs(d);
      done = (k >= NLAT[d]);
      chk($sformatf("key_ready/rpc%0d/c%0d", RPCS[d], k), 32'(o.key_ready), 32'(done));
      chk($sformatf("busy/rpc%0d/c%0d", RPCS[d], k), 32'(o.busy), 32'(!done));
      chk($sformatf("keys_ready/rpc%0d/c%0d", RPCS[d], k), 32'(o.keys_ready), 32'(done));
    end
  endtask

  task automatic reset_check(input string tag);
    outs_t o;
    for (int d = 0; d < 3; d++) begin
      o = get_outs(d);
      chk($sformatf("%s/key_ready/rpc%0d", tag, RPCS[d]), 32'(o.key_ready), 32'd1);
      chk($sformatf("%s/busy/rpc%0d", tag, RPCS[d]), 32'(o.busy), 32'd0);
      chk($sformatf("%s/keys_ready/rpc%0d", tag, RPCS[d]), 32'(o.keys_ready), 32'd0);
      chk($sformatf("%s/rd_valid/rpc%0d", tag, RPCS[d]), 32'(o.rd_valid), 32'd0);
      chk($sformatf("%s/rd_key/rpc%0d", tag, RPCS[d]), o.rd_key, 32'd0);
    end
  endtask

  // Handshake then track status for cycles 0..stop; glitch offers a bogus key mid-expansion.
  task automatic load_watch(input logic [127:0] mk, input int stop, input bit glitch);
    key_valid = 1'b1; key = mk;
    step();
    key_valid = 1'b0; rd_en = 1'b0;
    for (int k = 0; k <= stop; k++) begin
      if (k > 0) step();
      status(k);
      if (glitch && k == 2) begin key_valid = 1'b1; key = ~mk; end
      if (k == 4) key_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_check("por");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reads before any key: no valid, data stays at reset value.
    rd(1'b0, 0, 1'b0, 32'h0);
    rd(1'b1, 7, 1'b0, 32'h0);
    step();

    model(MK1);
    load_watch(MK1, 32, 1'b0);
    rd(1'b0, 0,  1'b1, 32'hF12186F9);
    rd(1'b0, 1,  1'b1, 32'h41662B61);
    rd(1'b0, 31, 1'b1, 32'h9124A012);
    for (int i = 0; i < 32; i++) rd(1'b0, i, 1'b1, mdl[i]);
    rd(1'b1, 0,  1'b1, 32'h9124A012);
    rd(1'b1, 31, 1'b1, 32'hF12186F9);
    for (int i = 0; i < 32; i++) rd(1'b1, i, 1'b1, mdl[31-i]);
    step();

    // Rekey with a read on the same edge: the read sees the old schedule.
    old5 = mdl[5];
    rd_en = 1'b1; rd_dec = 1'b0; rd_idx = 5'd5;
    sbq.push_back('{v: 1'b1, k: old5});
    model(MK2);
    load_watch(MK2, 32, 1'b1);
    for (int i = 0; i < 32; i++) rd(1'b0, i, 1'b1, mdl[i]);
    step();

    // Reset in the middle of an expansion.
    load_watch(MK1, 10, 1'b0);
    #3 rst_n = 1'b0;
    #1 reset_check("mid");
    sbq.delete();
    last_k = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(1'b0, 3, 1'b0, 32'h0);
    step();
    model(MK1);
    load_watch(MK1, 32, 1'b0);
    rd(1'b0, 0, 1'b1, 32'hF12186F9);
    rd(1'b1, 0, 1'b1, 32'h9124A012);
    for (int i = 0; i < 32; i++) rd(1'b0, i, 1'b1, mdl[i]);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
